apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 2: number of requesters, range 2..8.
REQ-002 Parameter ADDR_WIDTH, default `PADDR_SIZE: APB address width.
REQ-003 Parameter DATA_WIDTH, default `XLEN: APB data width.
REQ-004 Parameter TIMEOUT, default 255: maximum ACCESS cycles before forced termination; 0 disables the timeout.
REQ-005 Port clk  input  1  the single clock; all logic is on the rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port req_valid  input  REQ_NUM  per-requester transfer request.
REQ-008 Port req_ready  output  REQ_NUM  per-requester acceptance pulse.
REQ-009 Port req_addr  input  REQ_NUM x ADDR_WIDTH  request address.
REQ-010 Port req_write, req_prot, req_wdata, req_strb  input  REQ_NUM x (1, 3, DATA_WIDTH, DATA_WIDTH/8)  request attributes.
REQ-011 Port resp_valid  output  REQ_NUM  one-cycle completion pulse to the owning requester.
REQ-012 Port resp_rdata  output  DATA_WIDTH  read data; shared by all requesters, qualified by resp_valid.
REQ-013 Port resp_err  output  1  error flag; shared by all requesters, qualified by resp_valid.
REQ-014 Port apb  ApbIO.master  -  shared APB4 master port: paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pready, prdata, pslverr.

Function
REQ-015 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-016 In IDLE with any req_valid set, the arbiter SHALL grant exactly one requester in round-robin order starting at pointer rr_ptr.
REQ-017 On a grant, req_ready[g] SHALL pulse high in that same cycle, and the request fields SHALL be latched.
REQ-018 On a grant, the FSM SHALL move to SETUP, and rr_ptr SHALL become (g+1) mod REQ_NUM.
REQ-019 req_ready SHALL be zero in every state other than IDLE, and zero in IDLE when no request is valid.
REQ-020 In SETUP: psel=1, penable=0, and paddr, pprot, pwrite, pwdata and pstrb SHALL be driven from the latched values; the next state SHALL be ACCESS.
REQ-021 In ACCESS: psel=1, penable=1, with all APB fields held stable; the FSM SHALL stay in ACCESS while pready=0.
REQ-022 In ACCESS with pready=1, the FSM SHALL capture prdata and pslverr, then go to IDLE.
REQ-023 In the cycle after the pready capture, resp_valid[g] SHALL be 1 for exactly one cycle, with resp_rdata and resp_err holding the captured values.
REQ-024 Timeout counter: it SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-025 When TIMEOUT≠0 and the counter reaches TIMEOUT with pready still 0, the FSM SHALL leave ACCESS for IDLE.
REQ-026 On a timeout exit, the next-cycle response SHALL be resp_valid[g]=1, resp_err=1, resp_rdata=0.
REQ-027 If pready=1 arrives in the same cycle the counter reaches TIMEOUT, pready SHALL win and the normal response SHALL be returned.
REQ-028 A new grant SHALL be possible in the same cycle that resp_valid is asserted for the previous transfer, because the FSM is already in IDLE.
REQ-029 Minimum request-to-response latency SHALL be 3 cycles (grant T, SETUP T+1, ACCESS with pready T+2, resp_valid T+3), so one transfer occupies at least 3 cycles.
REQ-030 Deasserting req_valid after the grant cycle SHALL have no effect on the transfer in flight.
REQ-031 In IDLE, psel, penable, pwrite, paddr, pwdata, pstrb and pprot SHALL be 0.
REQ-032 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and saturate; it never wraps.

Reset
REQ-033 On rst=1, the FSM SHALL go to IDLE and rr_ptr SHALL become 0.
REQ-034 On rst=1, all outputs SHALL be 0: req_ready, resp_valid, resp_rdata, resp_err and all APB outputs.
REQ-035 On rst=1, the timeout counter and the latched request SHALL be cleared.
REQ-036 Reset mid-transfer (SETUP or ACCESS) SHALL abandon the transfer with no resp_valid, and psel SHALL be 0 in the cycle after rst is sampled.

Verification
REQ-037 Single read: req_valid[0]=1, addr=0x1000, and the slave returns pready=1 with prdata=0xDEADBEEF at the first ACCESS -> req_ready[0] at T, psel=1/penable=0 at T+1, penable=1 at T+2, resp_valid[0]=1 with rdata=0xDEADBEEF and err=0 at T+3.
REQ-038 Contention: req_valid=2'b11 held continuously, REQ_NUM=2 -> grants alternate 0,1,0,1, with each grant 3 cycles apart.
REQ-039 Wait states: the slave holds pready=0 for 4 ACCESS cycles -> APB fields stay stable and resp_valid arrives at T+7.
REQ-040 Timeout: TIMEOUT=8 and the slave never asserts pready -> exit after 8 ACCESS cycles; resp_err=1, resp_rdata=0, then the next request is granted normally.
REQ-041 Slave error: pslverr=1 with pready=1 on a write, strb=4'b0011 -> pstrb=4'b0011 is seen on the bus, and resp_err=1 to the requester.
REQ-042 Reset in ACCESS: rst=1 asserted for one cycle during a wait state -> next cycle psel=0, no resp_valid, rr_ptr=0; a subsequent request completes normally.

Source files
------------

// File: rtl/apb_arbiter_if.sv
// APB4 bus bundle shared between the arbiter (master side) and one slave.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface ApbIO #(
  parameter int ADDR_WIDTH = `PADDR_SIZE,
  parameter int DATA_WIDTH = `XLEN
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter funnelling REQ_NUM requesters onto one APB4 master port,
// with an optional ACCESS-phase timeout that returns an error response.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module apb_arbiter #(
  parameter int REQ_NUM    = 2,
  parameter int ADDR_WIDTH = `PADDR_SIZE,
  parameter int DATA_WIDTH = `XLEN,
  parameter int TIMEOUT    = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQ_NUM-1:0]                    req_valid,
  output logic [REQ_NUM-1:0]                    req_ready,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [REQ_NUM-1:0]                    req_write,
  input  logic [REQ_NUM-1:0][2:0]               req_prot,
  input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]    req_wdata,
  input  logic [REQ_NUM-1:0][DATA_WIDTH/8-1:0]  req_strb,
  output logic [REQ_NUM-1:0]                    resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_rdata,
  output logic                                  resp_err,
  ApbIO.master                                  apb
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(REQ_NUM - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [REQ_NUM-1:0]      resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;

  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;

  // Pick the first valid requester at or after rr_ptr and pulse its ready.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready   = '0;
    if (!rst && state_q == IDLE) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        cand = PTR_W'((int'(rr_ptr_q) + i) % REQ_NUM);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Next-state, bus-field and response computation for the transfer FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d  = SETUP;
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + PTR_W'(1);
          psel_d   = 1'b1;
          paddr_d  = req_addr[grant_idx];
          pprot_d  = req_prot[grant_idx];
          pwrite_d = req_write[grant_idx];
          pwdata_d = req_wdata[grant_idx];
          pstrb_d  = req_strb[grant_idx];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (apb.pready || (TIMEOUT != 0 && cnt_inc == CNT_LIMIT)) begin
          // A slave answer in the limit cycle still wins over the timeout.
          resp_valid_d[owner_q] = 1'b1;
          resp_rdata_d = apb.pready ? apb.prdata : '0;
          resp_err_d   = apb.pready ? apb.pslverr : 1'b1;
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          paddr_d   = '0;
          pprot_d   = '0;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          pstrb_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register FSM state, latched request / bus fields and the response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.pprot   = pprot_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: two requesters, 32-bit bus, TIMEOUT of 8.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [N-1:0]              req_valid = '0;
  logic [N-1:0]              req_ready;
  logic [N-1:0][AW-1:0]      req_addr  = '0;
  logic [N-1:0]              req_write = '0;
  logic [N-1:0][2:0]         req_prot  = '0;
  logic [N-1:0][DW-1:0]      req_wdata = '0;
  logic [N-1:0][DW/8-1:0]    req_strb  = '0;
  logic [N-1:0]              resp_valid;
  logic [DW-1:0]             resp_rdata;
  logic                      resp_err;

  int n_vec = 0;
  int n_err = 0;

  ApbIO #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_arbiter #(.REQ_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_prot   (req_prot),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .apb        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic w,
                         input logic [2:0] p, input logic [DW-1:0] d, input logic [3:0] s);
    req_addr[r]  = a;
    req_write[r] = w;
    req_prot[r]  = p;
    req_wdata[r] = d;
    req_strb[r]  = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;

    // Reset, with a request already pending: nothing may be granted.
    cyc(); req_valid = 2'b01; set_req(0, 32'h1000, 1'b0, 3'b010, 32'h0, 4'hF);
    cyc(); #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_psel", bus.psel, 1'b0);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", resp_err, 1'b0);

    // Single read from requester 0, slave ready at the first ACCESS cycle.
    cyc(); rst = 1'b0; #1;
    check("rd_ready", req_ready, 2'b01);
    check("rd_idle_psel", bus.psel, 1'b0);
    cyc(); req_valid = 2'b00; #1;
    check("rd_setup_psel", bus.psel, 1'b1);
    check("rd_setup_penable", bus.penable, 1'b0);
    check("rd_setup_paddr", bus.paddr, 32'h1000);
    check("rd_setup_pprot", bus.pprot, 3'b010);
    check("rd_setup_ready", req_ready, 2'b00);
    cyc(); bus.pready = 1'b1; bus.prdata = 32'hDEADBEEF; #1;
    check("rd_access_penable", bus.penable, 1'b1);
    check("rd_access_resp", resp_valid, 2'b00);
    cyc(); bus.pready = 1'b0; bus.prdata = '0; #1;
    check("rd_resp_valid", resp_valid, 2'b01);
    check("rd_resp_rdata", resp_rdata, 32'hDEADBEEF);
    check("rd_resp_err", resp_err, 1'b0);
    check("rd_idle_psel2", bus.psel, 1'b0);
    check("rd_idle_paddr", bus.paddr, 32'h0);
    cyc(); #1;
    check("rd_resp_pulse", resp_valid, 2'b00);

    // Wait states: requester 1, four ACCESS cycles with pready low.
    cyc(); req_valid = 2'b10; set_req(1, 32'h4000, 1'b0, 3'b001, 32'h12345678, 4'hF); #1;
    check("ws_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00; #1;
    check("ws_setup_penable", bus.penable, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("ws_penable", bus.penable, 1'b1);
      check("ws_paddr", bus.paddr, 32'h4000);
      check("ws_pwdata", bus.pwdata, 32'h12345678);
      check("ws_pprot", bus.pprot, 3'b001);
      check("ws_resp", resp_valid, 2'b00);
    end
    cyc(); bus.pready = 1'b1; bus.prdata = 32'hCAFEF00D; #1;
    check("ws_last_resp", resp_valid, 2'b00);
    cyc(); bus.pready = 1'b0; #1;
    check("ws_resp_valid", resp_valid, 2'b10);
    check("ws_resp_rdata", resp_rdata, 32'hCAFEF00D);
    check("ws_resp_err", resp_err, 1'b0);

    // Slave error on a partial-strobe write from requester 0.
    cyc(); req_valid = 2'b01; set_req(0, 32'h5000, 1'b1, 3'b000, 32'hA5A5A5A5, 4'b0011); #1;
    check("se_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00; #1;
    check("se_pstrb", bus.pstrb, 4'b0011);
    check("se_pwrite", bus.pwrite, 1'b1);
    check("se_pwdata", bus.pwdata, 32'hA5A5A5A5);
    cyc(); bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hFFFF0000; #1;
    check("se_access_pstrb", bus.pstrb, 4'b0011);
    cyc(); bus.pready = 1'b0; bus.pslverr = 1'b0; #1;
    check("se_resp_valid", resp_valid, 2'b01);
    check("se_resp_err", resp_err, 1'b1);

    // Timeout: requester 1, slave never ready; 8 ACCESS cycles then error.
    cyc(); req_valid = 2'b10; set_req(1, 32'h6000, 1'b0, 3'b000, 32'h0, 4'hF); #1;
    check("to_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      check("to_access_psel", bus.psel, 1'b1);
      check("to_access_resp", resp_valid, 2'b00);
    end
    cyc(); req_valid = 2'b01; set_req(0, 32'h8000, 1'b0, 3'b000, 32'h0, 4'hF); #1;
    check("to_exit_psel", bus.psel, 1'b0);
    check("to_resp_valid", resp_valid, 2'b10);
    check("to_resp_err", resp_err, 1'b1);
    check("to_resp_rdata", resp_rdata, 32'h0);
    check("to_next_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00; #1;
    check("to_next_paddr", bus.paddr, 32'h8000);
    cyc(); bus.pready = 1'b1; bus.prdata = 32'h0BADF00D;
    cyc(); bus.pready = 1'b0; #1;
    check("to_next_resp", resp_valid, 2'b01);
    check("to_next_rdata", resp_rdata, 32'h0BADF00D);
    check("to_next_err", resp_err, 1'b0);

    // pready arriving in the limit cycle wins over the timeout.
    cyc(); req_valid = 2'b10; set_req(1, 32'h9000, 1'b0, 3'b000, 32'h0, 4'hF);
    cyc(); req_valid = 2'b00;
    for (int i = 0; i < 7; i++) cyc();
    cyc(); bus.pready = 1'b1; bus.prdata = 32'h600DCAFE; #1;
    check("pw_last_psel", bus.psel, 1'b1);
    cyc(); bus.pready = 1'b0; #1;
    check("pw_resp_valid", resp_valid, 2'b10);
    check("pw_resp_err", resp_err, 1'b0);
    check("pw_resp_rdata", resp_rdata, 32'h600DCAFE);

    // Reset during an ACCESS wait state, requester 0 (pointer moves to 1).
    cyc(); req_valid = 2'b01; set_req(0, 32'h7000, 1'b1, 3'b000, 32'h55AA55AA, 4'hF); #1;
    check("rs_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    cyc();
    cyc(); rst = 1'b1; #1;
    check("rs_pre_psel", bus.psel, 1'b1);
    cyc(); rst = 1'b0; bus.pready = 1'b1; bus.prdata = 32'h77777777; #1;
    check("rs_psel", bus.psel, 1'b0);
    check("rs_penable", bus.penable, 1'b0);
    check("rs_paddr", bus.paddr, 32'h0);
    check("rs_resp", resp_valid, 2'b00);
    cyc(); #1;
    check("rs_no_resp", resp_valid, 2'b00);

    // Contention after reset: grants 0,1,0,1 three cycles apart.
    set_req(0, 32'h2000, 1'b0, 3'b000, 32'h0, 4'hF);
    set_req(1, 32'h3000, 1'b0, 3'b000, 32'h0, 4'hF);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      req_valid = 2'b11; #1;
      if (k % 3 == 0) begin
        check("ct_ready", req_ready, ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
        if (k > 0) check("ct_resp", resp_valid, ((k / 3) % 2 == 0) ? 2'b10 : 2'b01);
      end else begin
        check("ct_ready_gap", req_ready, 2'b00);
      end
      if (k % 3 == 1) check("ct_paddr", bus.paddr, ((k / 3) % 2 == 0) ? 32'h2000 : 32'h3000);
    end
    cyc(); req_valid = 2'b00; #1;
    check("ct_last_resp", resp_valid, 2'b10);
    check("ct_last_ready", req_ready, 2'b00);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
